fp_divider: RTL and testbench
=============================

// Module: fp_divider
// PURPOSE
// IEEE-754 single-precision divider z = a / b; iterative restoring division, one quotient bit per 2 cycles.
// Inverse companion of the FP multiplier in the SVHN CFU datapath: same stb/ack operand/result protocol, drop-in beside it.
// Round-to-nearest-even; denormals fully supported on inputs and output.
// PARAMETERS
// none (format fixed at binary32; widths come from fp_pkg)
// PORTS
// clk           in   1   clock; sole clock domain
// rst           in   1   synchronous active-high reset
// input_a       in   32  dividend
// input_a_stb   in   1   dividend valid
// input_a_ack   out  1   dividend accepted when ack & stb on a rising edge
// input_b       in   32  divisor
// input_b_stb   in   1   divisor valid
// input_b_ack   out  1   divisor accepted when ack & stb on a rising edge
// output_z      out  32  quotient, registered
// output_z_stb  out  1   quotient valid
// output_z_ack  in   1   consumer accepts z when stb & ack on a rising edge
// output_flags  out  5   {invalid,div_by_zero,overflow,underflow,inexact}; only with FP_DIV_FLAGS_EN
// BEHAVIOUR
// - Reset (sync, wins over any state): state=get_a; input_a_ack, input_b_ack, output_z_stb = 0; output_z = 0; flags = 0.
// - Reset mid-operation abandons the operation; no stb is produced for it.
// - Handshake: ack asserted the cycle after entering get_a/get_b; on ack&stb, capture operand, drop ack, advance.
//   a strictly before b. No new a is acked until z is consumed. z and stb held stable while output_z_ack is low.
// - FSM: get_a -> get_b -> unpack -> special_cases -> {put_z | normalise_a} -> normalise_b -> divide_0
//   -> (divide_1 <-> divide_2) x50 -> divide_3 -> normalise_1 -> normalise_2 -> round -> pack -> put_z -> get_a.
// - unpack: m = frac (23b into 24b), e = exp - 127 (10b signed), s = sign.
// - special_cases (priority order): either NaN -> 32'hFFC00000; inf/inf -> NaN; 0/0 -> NaN;
//   inf/x -> inf, sign a_s^b_s; x/inf -> signed zero; x/0 (x != 0) -> signed inf; 0/x -> signed zero.
//   Else: exp field 0 -> e = -126, else set m[23].
// - normalise_a/b: shift m left, e--, one bit per cycle until m[23]=1.
// - divide_0: z_s = a_s^b_s; z_e = a_e - b_e; dividend(51b) = a_m<<27; divisor = b_m; quotient = remainder = 0; count(6b) = 0.
// - divide_1: quotient<<=1; remainder = {remainder,dividend[50]}; dividend<<=1.
// - divide_2: if remainder >= divisor {quotient[0]=1; remainder -= divisor}; count==49 -> divide_3, else count++ -> divide_1.
// - divide_3: z_m = quotient[26:3]; guard = q[2]; round_bit = q[1]; sticky = q[0] | (remainder != 0).
// - normalise_1: while z_m[23]==0 {z_m = {z_m[22:0],guard}; guard = round_bit; round_bit = 0; z_e--}.
// - normalise_2: while z_e < -126 {z_m>>=1; guard = z_m[0]; round_bit = guard; sticky |= round_bit; z_e++}.
// - round: if guard & (round_bit|sticky|z_m[0]) {z_m++; z_m==24'hFFFFFF -> z_e++}.
// - pack: {z_s, z_e+127, z_m[22:0]}; z_e==-126 & !z_m[23] -> exp field 0; z_e > 127 -> signed inf.
// - Latency, normal operands with a_m >= b_m: output_z_stb high 111 cycles after b handshake edge;
//   +1 per extra normalise cycle. Special cases: stb 3 cycles after b handshake.
// CONFIGURATION
// - FP_DIV_FLAGS_EN defined: output_flags present, updated in pack/special_cases, valid with output_z_stb,
//   held until consumed; invalid = NaN result from non-NaN operands or NaN input, div_by_zero = x/0 with finite x != 0,
//   overflow = inf from finite, underflow = tiny & inexact, inexact = guard|round_bit|sticky.
// - Undefined: port and logic absent; datapath and latency identical.
// STRUCTURE
// - fp_pkg: state enum encodings, EXP_BIAS=127, EXP_MIN=-126, canonical NaN 32'hFFC00000, INF exp 8'hFF, flag bit indices.
// - One sub-module: fp_classify (combinational: is_zero/is_denorm/is_inf/is_nan per operand), shared with the multiplier.
// TESTING
// - 6.0/2.0: 40C00000 / 40000000 -> 40400000; 1.0/3.0: 3F800000 / 40400000 -> 3EAAAAAB (round-up path, inexact).
// - Specials: 3F800000/00000000 -> 7F800000 (div_by_zero); 00000000/00000000 -> FFC00000 (invalid);
//   7F800000/7F800000 -> FFC00000; BF800000/7F800000 -> 80000000.
// - Overflow 7F7FFFFF / 3F000000 -> 7F800000 (overflow|inexact); denormal out 00800000 / 40000000 -> 00400000.
// - Denormal in 00000001 / 3F000000 -> 00000002; checks normalise_a loop and extra latency.
// - Backpressure: hold output_z_ack low 20 cycles -> stb and z stable, input_a_ack stays 0; release -> stb drops next cycle.
// - Reset pulse during divide_1 loop -> no stb; next operand pair 40C00000/40000000 -> 40400000 at nominal latency.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the binary32 arithmetic blocks: divider FSM encodings,
// exponent limits, canonical NaN and exception-flag bit positions.
package fp_pkg;

    typedef enum logic [3:0] {
        ST_GET_A,
        ST_GET_B,
        ST_UNPACK,
        ST_SPECIAL,
        ST_NORM_A,
        ST_NORM_B,
        ST_DIV_0,
        ST_DIV_1,
        ST_DIV_2,
        ST_DIV_3,
        ST_NORM_1,
        ST_NORM_2,
        ST_ROUND,
        ST_PACK,
        ST_PUT_Z
    } div_state_t;

    localparam logic signed [9:0] EXP_BIAS = 10'sd127;
    localparam logic signed [9:0] EXP_MIN  = -10'sd126;
    localparam logic signed [9:0] EXP_MAX  = 10'sd127;
    localparam logic [31:0]       CANON_NAN = 32'hFFC00000;
    localparam logic [7:0]        EXP_INF   = 8'hFF;

    // Index of the last of the 50 restoring-division steps
    localparam logic [5:0] DIV_STEPS_LAST = 6'd49;

    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_DIV_ZERO  = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier for binary32 (sign excluded): zero, denormal,
// infinity, NaN. Shared by the FP multiplier and divider.
module fp_classify
    import fp_pkg::*;
(
    input  logic [30:0] i_op,
    output logic        o_is_zero,
    output logic        o_is_denorm,
    output logic        o_is_inf,
    output logic        o_is_nan
);

    logic [7:0]  w_exp;
    logic [22:0] w_frac;

    assign w_exp  = i_op[30:23];
    assign w_frac = i_op[22:0];

    assign o_is_zero   = (w_exp == 8'd0)    && (w_frac == 23'd0);
    assign o_is_denorm = (w_exp == 8'd0)    && (w_frac != 23'd0);
    assign o_is_inf    = (w_exp == EXP_INF) && (w_frac == 23'd0);
    assign o_is_nan    = (w_exp == EXP_INF) && (w_frac != 23'd0);

endmodule

// File: rtl/fp_divider.sv
// Binary32 divider z = a / b, restoring division (one quotient bit per two cycles),
// round-to-nearest-even, denormals in and out. FP_DIV_FLAGS_EN adds output_flags.
module fp_divider
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
`ifdef FP_DIV_FLAGS_EN
    output logic [4:0]  output_flags,
`endif
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    div_state_t        r_state;
    logic              r_a_ack, r_b_ack, r_z_stb;
    logic [31:0]       r_output_z, r_a, r_b, r_z;
    logic [23:0]       r_a_m, r_b_m, r_z_m, r_divisor;
    logic signed [9:0] r_a_e, r_b_e, r_z_e;
    logic              r_a_s, r_b_s, r_z_s;
    logic              r_guard, r_round_bit, r_sticky;
    logic [50:0]       r_dividend;
    logic [26:0]       r_quotient;
    logic [24:0]       r_remainder;
    logic [5:0]        r_count;

    logic [30:0] w_ops [2];
    logic [1:0]  w_zero, w_denorm, w_inf, w_nan;
    logic        w_sign, w_tiny, w_overflow;

    assign w_ops[0] = r_a[30:0];
    assign w_ops[1] = r_b[30:0];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_classify
            fp_classify u_classify (
                .i_op        (w_ops[gi]),
                .o_is_zero   (w_zero[gi]),
                .o_is_denorm (w_denorm[gi]),
                .o_is_inf    (w_inf[gi]),
                .o_is_nan    (w_nan[gi])
            );
        end
    endgenerate

    assign w_sign     = r_a_s ^ r_b_s;
    assign w_tiny     = (r_z_e == EXP_MIN) && !r_z_m[23];
    assign w_overflow = r_z_e > EXP_MAX;

`ifdef FP_DIV_FLAGS_EN
    logic [4:0] r_flags;
    logic [4:0] w_pack_flags;
    logic       w_inexact;

    always_comb begin
        w_inexact    = r_guard | r_round_bit | r_sticky;
        w_pack_flags = '0;
        w_pack_flags[FLAG_OVERFLOW]  = w_overflow;
        w_pack_flags[FLAG_UNDERFLOW] = w_tiny & w_inexact;
        // Overflow to infinity always loses the true magnitude
        w_pack_flags[FLAG_INEXACT]   = w_inexact | w_overflow;
    end

    assign output_flags = r_flags;
`endif

    assign input_a_ack  = r_a_ack;
    assign input_b_ack  = r_b_ack;
    assign output_z     = r_output_z;
    assign output_z_stb = r_z_stb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_GET_A;
            r_a_ack    <= 1'b0;
            r_b_ack    <= 1'b0;
            r_z_stb    <= 1'b0;
            r_output_z <= 32'd0;
`ifdef FP_DIV_FLAGS_EN
            r_flags    <= '0;
`endif
        end else begin
            case (r_state)
                ST_GET_A: begin
                    r_a_ack <= 1'b1;
                    if (r_a_ack && input_a_stb) begin
                        r_a     <= input_a;
                        r_a_ack <= 1'b0;
                        r_state <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    r_b_ack <= 1'b1;
                    if (r_b_ack && input_b_stb) begin
                        r_b     <= input_b;
                        r_b_ack <= 1'b0;
                        r_state <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    r_a_m   <= {1'b0, r_a[22:0]};
                    r_b_m   <= {1'b0, r_b[22:0]};
                    r_a_e   <= $signed({2'b00, r_a[30:23]}) - EXP_BIAS;
                    r_b_e   <= $signed({2'b00, r_b[30:23]}) - EXP_BIAS;
                    r_a_s   <= r_a[31];
                    r_b_s   <= r_b[31];
                    r_state <= ST_SPECIAL;
                end
                ST_SPECIAL: begin
                    r_state <= ST_PUT_Z;
`ifdef FP_DIV_FLAGS_EN
                    r_flags <= '0;
`endif
                    if (w_nan[0] || w_nan[1] || (w_inf[0] && w_inf[1]) || (w_zero[0] && w_zero[1])) begin
                        r_z <= CANON_NAN;
`ifdef FP_DIV_FLAGS_EN
                        r_flags <= 5'd1 << FLAG_INVALID;
`endif
                    end else if (w_inf[0]) begin
                        r_z <= {w_sign, EXP_INF, 23'd0};
                    end else if (w_inf[1]) begin
                        r_z <= {w_sign, 31'd0};
                    end else if (w_zero[1]) begin
                        r_z <= {w_sign, EXP_INF, 23'd0};
`ifdef FP_DIV_FLAGS_EN
                        r_flags <= 5'd1 << FLAG_DIV_ZERO;
`endif
                    end else if (w_zero[0]) begin
                        r_z <= {w_sign, 31'd0};
                    end else begin
                        if (w_denorm[0]) r_a_e <= EXP_MIN;
                        else             r_a_m[23] <= 1'b1;
                        if (w_denorm[1]) r_b_e <= EXP_MIN;
                        else             r_b_m[23] <= 1'b1;
                        r_state <= ST_NORM_A;
                    end
                end
                ST_NORM_A: begin
                    if (r_a_m[23]) begin
                        r_state <= ST_NORM_B;
                    end else begin
                        r_a_m <= r_a_m << 1;
                        r_a_e <= r_a_e - 10'sd1;
                    end
                end
                ST_NORM_B: begin
                    if (r_b_m[23]) begin
                        r_state <= ST_DIV_0;
                    end else begin
                        r_b_m <= r_b_m << 1;
                        r_b_e <= r_b_e - 10'sd1;
                    end
                end
                ST_DIV_0: begin
                    r_z_s       <= w_sign;
                    r_z_e       <= r_a_e - r_b_e;
                    r_dividend  <= {r_a_m, 27'd0};
                    r_divisor   <= r_b_m;
                    r_quotient  <= '0;
                    r_remainder <= '0;
                    r_count     <= '0;
                    r_state     <= ST_DIV_1;
                end
                ST_DIV_1: begin
                    r_quotient  <= r_quotient << 1;
                    r_remainder <= {r_remainder[23:0], r_dividend[50]};
                    r_dividend  <= r_dividend << 1;
                    r_state     <= ST_DIV_2;
                end
                ST_DIV_2: begin
                    if (r_remainder >= {1'b0, r_divisor}) begin
                        r_quotient[0] <= 1'b1;
                        r_remainder   <= r_remainder - {1'b0, r_divisor};
                    end
                    if (r_count == DIV_STEPS_LAST) begin
                        r_state <= ST_DIV_3;
                    end else begin
                        r_count <= r_count + 6'd1;
                        r_state <= ST_DIV_1;
                    end
                end
                ST_DIV_3: begin
                    r_z_m       <= r_quotient[26:3];
                    r_guard     <= r_quotient[2];
                    r_round_bit <= r_quotient[1];
                    r_sticky    <= r_quotient[0] | (r_remainder != 25'd0);
                    r_state     <= ST_NORM_1;
                end
                ST_NORM_1: begin
                    if (!r_z_m[23]) begin
                        r_z_m       <= {r_z_m[22:0], r_guard};
                        r_guard     <= r_round_bit;
                        r_round_bit <= 1'b0;
                        r_z_e       <= r_z_e - 10'sd1;
                    end else begin
                        r_state <= ST_NORM_2;
                    end
                end
                ST_NORM_2: begin
                    // Denormalise results below the smallest normal exponent
                    if (r_z_e < EXP_MIN) begin
                        r_z_m       <= r_z_m >> 1;
                        r_guard     <= r_z_m[0];
                        r_round_bit <= r_guard;
                        r_sticky    <= r_sticky | r_round_bit;
                        r_z_e       <= r_z_e + 10'sd1;
                    end else begin
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (r_guard && (r_round_bit || r_sticky || r_z_m[0])) begin
                        r_z_m <= r_z_m + 24'd1;
                        if (r_z_m == 24'hFFFFFF) r_z_e <= r_z_e + 10'sd1;
                    end
                    r_state <= ST_PACK;
                end
                ST_PACK: begin
                    if (w_overflow)
                        r_z <= {r_z_s, EXP_INF, 23'd0};
                    else if (w_tiny)
                        r_z <= {r_z_s, 8'd0, r_z_m[22:0]};
                    else
                        r_z <= {r_z_s, r_z_e[7:0] + EXP_BIAS[7:0], r_z_m[22:0]};
`ifdef FP_DIV_FLAGS_EN
                    r_flags <= w_pack_flags;
`endif
                    r_state <= ST_PUT_Z;
                end
                ST_PUT_Z: begin
                    r_z_stb    <= 1'b1;
                    r_output_z <= r_z;
                    if (r_z_stb && output_z_ack) begin
                        r_z_stb <= 1'b0;
                        r_state <= ST_GET_A;
                    end
                end
                default: r_state <= ST_GET_A;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// Directed-vector bench for fp_divider: results, latency, specials, backpressure,
// mid-operation reset; flags are checked too when FP_DIV_FLAGS_EN is defined.
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] input_a = '0;
    logic        input_a_stb = 1'b0;
    logic        input_a_ack;
    logic [31:0] input_b = '0;
    logic        input_b_stb = 1'b0;
    logic        input_b_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack = 1'b0;
`ifdef FP_DIV_FLAGS_EN
    logic [4:0]  output_flags;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    fp_divider dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .input_b_ack  (input_b_ack),
        .output_z     (output_z),
`ifdef FP_DIV_FLAGS_EN
        .output_flags (output_flags),
`endif
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Hands over a then b; c0 is the cycle count just after the b handshake edge.
    task automatic send_op(input logic [31:0] a, input logic [31:0] b, output int c0);
        int n;
        @(negedge clk);
        input_a = a;
        input_a_stb = 1'b1;
        n = 0;
        while (!input_a_ack && n < 300) begin @(negedge clk); n++; end
        check_eq("a_ack", {31'd0, input_a_ack}, 32'd1);
        @(posedge clk); #1 input_a_stb = 1'b0;
        @(negedge clk);
        input_b = b;
        input_b_stb = 1'b1;
        n = 0;
        while (!input_b_ack && n < 300) begin @(negedge clk); n++; end
        check_eq("b_ack", {31'd0, input_b_ack}, 32'd1);
        @(posedge clk); #1 input_b_stb = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_z(input int c0, output int lat);
        int n = 0;
        while (!output_z_stb && n < 400) begin @(negedge clk); n++; end
        check_eq("z_stb", {31'd0, output_z_stb}, 32'd1);
        lat = cyc - c0;
    endtask

    task automatic consume();
        @(negedge clk);
        output_z_ack = 1'b1;
        @(posedge clk); #1 output_z_ack = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_z, input int exp_lat, input logic [4:0] exp_fl);
        int c0, lat;
        send_op(a, b, c0);
        wait_z(c0, lat);
        check_eq({tag, "_z"}, output_z, exp_z);
        check_eq({tag, "_lat"}, lat, exp_lat);
`ifdef FP_DIV_FLAGS_EN
        check_eq({tag, "_flags"}, {27'd0, output_flags}, {27'd0, exp_fl});
`endif
        $display("op %s: %08h / %08h -> %08h latency %0d (expected flags %05b)",
                 tag, a, b, output_z, lat, exp_fl);
        consume();
    endtask

    initial begin
        int c0, lat, bad_stb, bad_z, bad_ack, seen;

        repeat (3) @(negedge clk);
        check_eq("rst_z_stb", {31'd0, output_z_stb}, 32'd0);
        check_eq("rst_z", output_z, 32'd0);
        check_eq("rst_a_ack", {31'd0, input_a_ack}, 32'd0);
        check_eq("rst_b_ack", {31'd0, input_b_ack}, 32'd0);
        rst = 1'b0;

        run("div6_2",     32'h40C00000, 32'h40000000, 32'h40400000, 111, 5'b00000);
        run("one_third",  32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 112, 5'b00001);
        run("neg_half",   32'h40000000, 32'hC0800000, 32'hBF000000, 111, 5'b00000);
        run("x_div_0",    32'h3F800000, 32'h00000000, 32'h7F800000,   3, 5'b01000);
        run("zero_zero",  32'h00000000, 32'h00000000, 32'hFFC00000,   3, 5'b10000);
        run("inf_inf",    32'h7F800000, 32'h7F800000, 32'hFFC00000,   3, 5'b10000);
        run("x_div_inf",  32'hBF800000, 32'h7F800000, 32'h80000000,   3, 5'b00000);
        run("nan_in",     32'h7FC00001, 32'h3F800000, 32'hFFC00000,   3, 5'b10000);
        run("zero_x",     32'h00000000, 32'h40A00000, 32'h00000000,   3, 5'b00000);
        run("overflow",   32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 111, 5'b00101);
        run("denorm_out", 32'h00800000, 32'h40000000, 32'h00400000, 112, 5'b00000);
        run("denorm_in",  32'h00000001, 32'h3F000000, 32'h00000002, 156, 5'b00000);

        // Backpressure: result held for 20 cycles, no new dividend accepted meanwhile
        send_op(32'h40C00000, 32'h40000000, c0);
        wait_z(c0, lat);
        check_eq("bp_lat", lat, 111);
        input_a = 32'h3F800000;
        input_a_stb = 1'b1;
        bad_stb = 0; bad_z = 0; bad_ack = 0;
        repeat (20) begin
            @(negedge clk);
            if (!output_z_stb) bad_stb++;
            if (output_z !== 32'h40400000) bad_z++;
            if (input_a_ack) bad_ack++;
        end
        check_eq("bp_stb_held", bad_stb, 0);
        check_eq("bp_z_held", bad_z, 0);
        check_eq("bp_a_ack_low", bad_ack, 0);
        input_a_stb = 1'b0;
        @(negedge clk);
        output_z_ack = 1'b1;
        @(posedge clk); #1 output_z_ack = 1'b0;
        check_eq("bp_stb_drop", {31'd0, output_z_stb}, 32'd0);
        $display("op backpressure: 40c00000 / 40000000 held 20 cycles, released");

        // Reset in the middle of the division loop abandons the operation
        send_op(32'h40C00000, 32'h40000000, c0);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mid_z", output_z, 32'd0);
        seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (output_z_stb) seen = 1;
        end
        check_eq("rst_mid_no_stb", seen, 0);
        $display("op mid_reset: 40c00000 / 40000000 abandoned");
        run("after_rst",  32'h40C00000, 32'h40000000, 32'h40400000, 111, 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
